taylor_pipe_ctrl: RTL and testbench

- Control sequencer for a chain of `STAGES` pipelined Taylor-series slices, each of which computes one series term and adds it to a running sum.
- Accepts one evaluation request per cycle through a valid/ready handshake.
- Per stage and per request, it drives the coefficient-bank select and the add/bypass select, plus one global pipeline-advance enable for the datapath register banks.
- Tracks valid, function and overflow state alongside the data, and presents a valid/ready result handshake at the chain output.

---
 rtl/taylor_pipe_ctrl.sv | 82 ++++++++
 tb/tb_taylor_pipe_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taylor_pipe_ctrl.sv
// Control sequencer for a STAGES-deep chain of pipelined Taylor-series slices.
// Define TAYLOR_CTRL_PERF_EN to build the output-stall cycle counter on stall_cnt.
module taylor_pipe_ctrl #(
    parameter int STAGES = 4,
    parameter int TW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_func,
    input  logic [TW-1:0]     in_terms,
    output logic              pipe_en,
    output logic [STAGES-1:0] stage_addr,
    output logic [STAGES-1:0] stage_sel_sum,
    input  logic [STAGES-1:0] stage_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_func,
    output logic              out_overflow,
    output logic [31:0]       stall_cnt
);
    localparam logic [TW-1:0] MAX_TERMS = TW'(STAGES);

    // Banks 0..STAGES; the term count is only consumed by slices, so bank STAGES has none.
    logic [STAGES:0] v;
    logic [STAGES:0] func;
    logic [STAGES:0] ovf;
    logic [TW-1:0]   terms [STAGES];
    logic [TW-1:0]   sat_terms;

    assign sat_terms    = (in_terms > MAX_TERMS) ? MAX_TERMS : in_terms;
    assign pipe_en      = ~v[STAGES] | out_ready;
    assign in_ready     = pipe_en;
    assign out_valid    = v[STAGES];
    assign out_func     = func[STAGES];
    assign out_overflow = ovf[STAGES];

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        stage_addr    = '0;
        stage_sel_sum = '1;
        for (int k = 0; k < STAGES; k++) begin
            stage_addr[k]    = func[k];
            stage_sel_sum[k] = ~v[k] | (TW'(k) >= terms[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v    <= '0;
            func <= '0;
            ovf  <= '0;
            // NOTE: the per-bank term registers are cleared too so reset state is fully defined.
            for (int k = 0; k < STAGES; k++) terms[k] <= '0;
        end else if (pipe_en) begin
            v[0]     <= in_valid;
            func[0]  <= in_func;
            ovf[0]   <= 1'b0;
            terms[0] <= sat_terms;
            for (int k = 0; k < STAGES; k++) begin
                v[k+1]    <= v[k];
                func[k+1] <= func[k];
                // Only an adding, valid slice may tag its own item; the flag then rides along.
                ovf[k+1]  <= ovf[k] | (v[k] & ~stage_sel_sum[k] & stage_ovf[k]);
            end
            for (int k = 1; k < STAGES; k++) terms[k] <= terms[k-1];
        end
    end

`ifdef TAYLOR_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid & ~out_ready)
            stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_taylor_pipe_ctrl.sv
// Scoreboard bench for taylor_pipe_ctrl: item-level reference model, directed phases, random traffic.
module tb_taylor_pipe_ctrl;
    localparam int STAGES = 4;
    localparam int TW     = 3;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_func;
    logic [TW-1:0]     in_terms;
    logic              pipe_en;
    logic [STAGES-1:0] stage_addr;
    logic [STAGES-1:0] stage_sel_sum;
    logic [STAGES-1:0] stage_ovf;
    logic              out_valid;
    logic              out_ready;
    logic              out_func;
    logic              out_overflow;
    logic [31:0]       stall_cnt;

    taylor_pipe_ctrl #(.STAGES(STAGES), .TW(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_func      (in_func),
        .in_terms     (in_terms),
        .pipe_en      (pipe_en),
        .stage_addr   (stage_addr),
        .stage_sel_sum(stage_sel_sum),
        .stage_ovf    (stage_ovf),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_func     (out_func),
        .out_overflow (out_overflow),
        .stall_cnt    (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each accepted request is an item that has advanced 'pos' slices.
    typedef struct {
        bit func;
        int terms;
        bit ovf;
        int pos;
    } item_t;

    typedef struct {
        bit func;
        bit ovf;
    } exp_t;

    item_t inflight[$];
    exp_t  exp_q[$];
    int    m_stall;
    int    n_pass;
    int    n_total;
    bit    mon_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    bit m_full;
    int m_k;
    always @(posedge clk) begin
        if (rst) begin
            inflight.delete();
            exp_q.delete();
            m_stall = 0;
        end else begin
            m_full = (inflight.size() > 0) && (inflight[0].pos == STAGES);
            if (m_full && !out_ready) m_stall++;
            if (!m_full || out_ready) begin
                if (m_full) void'(inflight.pop_front());
                foreach (inflight[i]) begin
                    m_k = inflight[i].pos;
                    if (m_k < inflight[i].terms && stage_ovf[m_k]) inflight[i].ovf = 1'b1;
                    inflight[i].pos = m_k + 1;
                    if (m_k + 1 == STAGES) exp_q.push_back('{inflight[i].func, inflight[i].ovf});
                end
                if (in_valid)
                    inflight.push_back('{in_func,
                                         (int'(in_terms) > STAGES) ? STAGES : int'(in_terms),
                                         1'b0, 0});
            end
        end
    end

    logic [STAGES-1:0] e_addr;
    logic [STAGES-1:0] e_sel;
    bit                e_valid;
    bit                e_func;
    bit                e_ovf;
    int                e_stall;
    exp_t              e_item;
    always @(negedge clk) begin
        if (mon_en) begin
            e_addr  = '0;
            e_sel   = '1;
            e_valid = 1'b0;
            e_func  = 1'b0;
            e_ovf   = 1'b0;
            foreach (inflight[i]) begin
                if (inflight[i].pos < STAGES) begin
                    e_addr[inflight[i].pos] = inflight[i].func;
                    e_sel[inflight[i].pos]  = (inflight[i].pos >= inflight[i].terms);
                end else begin
                    e_valid = 1'b1;
                    e_func  = inflight[i].func;
                    e_ovf   = inflight[i].ovf;
                end
            end
`ifdef TAYLOR_CTRL_PERF_EN
            e_stall = m_stall;
`else
            e_stall = 0;
`endif
            check("out_valid", out_valid, e_valid);
            check("out_func", out_func, e_func);
            check("out_overflow", out_overflow, e_ovf);
            check("in_ready", in_ready, !e_valid || out_ready);
            check("pipe_en", pipe_en, !e_valid || out_ready);
            check("stage_addr", stage_addr, e_addr);
            check("stage_sel_sum", stage_sel_sum, e_sel);
            check("stall_cnt", stall_cnt, e_stall);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_pop: result presented, got none expected (t=%0t)", $time);
                end else begin
                    e_item = exp_q.pop_front();
                    check("sb_func", out_func, e_item.func);
                    check("sb_ovf", out_overflow, e_item.ovf);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds a request until it is accepted; returns just after the accepting edge.
    task automatic send(input logic f, input logic [TW-1:0] t);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_func  = f;
        in_terms = t;
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 60) begin
                n_total++;
                $display("FAIL send_timeout: got no accept, expected accept within 60 cycles");
                break;
            end
        end
        in_valid = 1'b0;
        in_func  = 1'b0;
    endtask

    logic [TW-1:0] ovf_terms [5] = '{3'd4, 3'd4, 3'd4, 3'd1, 3'd4};
    bit            ovf_flag  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_func   = 1'b0;
        in_terms  = '0;
        out_ready = 1'b1;
        stage_ovf = '0;
        mon_en    = 1'b0;
        n_pass    = 0;
        n_total   = 0;
        m_stall   = 0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single full-length request.
        send(1'b1, 3'd4);
        idle(8);

        // Partial terms, then an over-range count that saturates.
        send(1'b0, 3'd2);
        send(1'b1, 3'd7);
        idle(8);

        // Back-pressure: six back-to-back requests, consumer stalls three cycles.
        fork
            begin
                for (int i = 0; i < 6; i++) send(1'(i & 1), 3'd4);
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 60);
                if (!out_valid) begin
                    n_total++;
                    $display("FAIL bp_first_result: got no out_valid, expected one within 60 cycles");
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(10);
`ifdef TAYLOR_CTRL_PERF_EN
        check("bp_stall_cnt", stall_cnt, 32'd3);
`else
        check("bp_stall_cnt", stall_cnt, 32'd0);
`endif

        // Overflow tagging on slice 1: an adding item, a bypassing item, clean neighbours.
        for (int i = 0; i < 5; i++) begin
            send(1'(i & 1), ovf_terms[i]);
            stage_ovf = (i >= 1 && ovf_flag[i-1]) ? 4'b0010 : 4'b0000;
        end
        @(posedge clk);
        #1;
        stage_ovf = ovf_flag[4] ? 4'b0010 : 4'b0000;
        @(posedge clk);
        #1;
        stage_ovf = '0;
        idle(8);

        // Reset with three items in flight.
        for (int i = 0; i < 3; i++) send(1'b1, 3'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("rst_out_valid", out_valid, 1'b0);
            @(posedge clk);
            #1;
        end

        // Full pipe, then retire and accept in the same cycle.
        out_ready = 1'b0;
        for (int i = 0; i < STAGES + 1; i++) send(1'b1, 3'($urandom_range(0, 7)));
        idle(1);
        in_valid  = 1'b1;
        in_func   = 1'b1;
        in_terms  = 3'd3;
        out_ready = 1'b1;
        @(negedge clk);
        check("simul_in_ready", in_ready, 1'b1);
        check("simul_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_func  = 1'b0;
        @(negedge clk);
        check("simul_still_full", out_valid, 1'b1);
        @(posedge clk);
        #1;
        idle(8);

        // Random traffic with random consumer stalls and overflow flags.
        repeat (300) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_func   = in_valid ? 1'($urandom_range(0, 1)) : 1'b0;
            in_terms  = TW'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            stage_ovf = STAGES'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_func   = 1'b0;
        out_ready = 1'b1;
        stage_ovf = '0;
        idle(12);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
